// File: rtl/load_seq_ctrl.sv
// Load sequencer: reads rs1, forms EA, issues one word read, extracts/extends, writes rd.
// Optional LOAD_MISALIGN_TRAP_EN traps misaligned LH/LHU/LW instead of executing them.
module load_seq_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rd,
    input  logic [11:0]       imm,
    input  logic [2:0]        funct3,
    output logic [4:0]        rf_raddr,
    input  logic [31:0]       rf_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    output logic              wb_en,
    output logic [4:0]        wb_addr,
    output logic [31:0]       wb_data,
    output logic              busy,
    output logic              illegal_err,
    output logic              misalign_err
);

    typedef enum logic [2:0] {IDLE, ADDR, REQ, WAIT, WB} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [4:0]          r_rs1;
    logic [4:0]          r_rd;
    logic [11:0]         r_imm;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_ea;
    logic                r_wb_en;
    logic [4:0]          r_wb_addr;
    logic [31:0]         r_wb_data;
    logic signed [11:0]  w_imm_s;
    logic [ADDR_W-1:0]   w_ea;
    logic                w_illegal;
    logic                w_misalign;

    function automatic logic [31:0] f_extract(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{lo, 3'b000} +: 8];
        h = d[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return d;
        endcase
    endfunction

    assign w_imm_s   = r_imm;
    assign w_ea      = ADDR_W'(rf_rdata) + ADDR_W'(w_imm_s);
    assign w_illegal = (r_funct3 == 3'b011) || (r_funct3[2:1] == 2'b11);

`ifdef LOAD_MISALIGN_TRAP_EN
    assign w_misalign = (((r_funct3 == 3'b001) || (r_funct3 == 3'b101)) && w_ea[0]) ||
                        ((r_funct3 == 3'b010) && (w_ea[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (issue_valid) w_next = ADDR;
            ADDR:    w_next = (w_illegal || w_misalign) ? IDLE : REQ;
            REQ:     if (mem_req_ready) w_next = WAIT;
            WAIT:    if (mem_rsp_valid) w_next = WB;
            WB:      w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rs1     <= '0;
            r_rd      <= '0;
            r_imm     <= '0;
            r_funct3  <= '0;
            r_ea      <= '0;
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            r_state <= w_next;
            r_wb_en <= 1'b0;
            if (r_state == IDLE && issue_valid) begin
                r_rs1    <= rs1;
                r_rd     <= rd;
                r_imm    <= imm;
                r_funct3 <= funct3;
            end
            if (r_state == ADDR) r_ea <= w_ea;
            // Writeback registers load on entry to WB so they hold steady outside WB.
            if (r_state == WAIT && mem_rsp_valid) begin
                r_wb_en   <= (r_rd != 5'd0);
                r_wb_addr <= r_rd;
                r_wb_data <= f_extract(r_funct3, r_ea[1:0], mem_rsp_data);
            end
        end
    end

    assign issue_ready   = (r_state == IDLE);
    assign busy          = (r_state != IDLE);
    assign rf_raddr      = r_rs1;
    assign mem_req_valid = (r_state == REQ);
    assign mem_addr      = {r_ea[ADDR_W-1:2], 2'b00};
    assign wb_en         = r_wb_en;
    assign wb_addr       = r_wb_addr;
    assign wb_data       = r_wb_data;
    assign illegal_err   = (r_state == ADDR) && w_illegal;
    assign misalign_err  = (r_state == ADDR) && w_misalign;

endmodule

// File: tb/tb_load_seq_ctrl.sv
// Directed bench for load_seq_ctrl with a small register-file model and hand-computed results.
module tb_load_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [11:0] imm;
    logic [2:0]  funct3;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy;
    logic        illegal_err;
    logic        misalign_err;

    logic [31:0] rf [32];
    int          n_checks;
    int          n_errors;

    load_seq_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .rs1(rs1), .rd(rd), .imm(imm), .funct3(funct3),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy), .illegal_err(illegal_err), .misalign_err(misalign_err)
    );

    assign rf_rdata = rf[rf_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input string tag, input logic [4:0] a_rs1, input logic [4:0] a_rd,
                            input logic [11:0] a_imm, input logic [2:0] a_f3,
                            input logic [31:0] rfv, input logic [31:0] rsp,
                            input logic [31:0] exp_addr, input logic [31:0] exp_data,
                            input logic exp_wb);
        rf[a_rs1]   = rfv;
        issue_valid = 1'b1;
        rs1 = a_rs1; rd = a_rd; imm = a_imm; funct3 = a_f3;
        #1;
        check({tag, " ready"}, 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0;
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " raddr"}, 32'(rf_raddr), 32'(a_rs1));
        check({tag, " noerr"}, 32'({illegal_err, misalign_err}), 32'd0);
        tick();
        check({tag, " req_valid"}, 32'(mem_req_valid), 32'd1);
        check({tag, " mem_addr"}, mem_addr, exp_addr);
        tick();
        check({tag, " req_done"}, 32'(mem_req_valid), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rsp;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        check({tag, " wb_en"}, 32'(wb_en), 32'(exp_wb));
        check({tag, " wb_addr"}, 32'(wb_addr), 32'(a_rd));
        check({tag, " wb_data"}, wb_data, exp_data);
        tick();
        check({tag, " wb_en_off"}, 32'(wb_en), 32'd0);
        check({tag, " wb_hold"}, wb_data, exp_data);
        check({tag, " idle"}, 32'(issue_ready), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rst_n = 1'b0;
        issue_valid = 1'b0; rs1 = '0; rd = '0; imm = '0; funct3 = '0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst ready", 32'(issue_ready), 32'd1);
        check("rst outs", 32'({mem_req_valid, wb_en, illegal_err, misalign_err}), 32'd0);
        check("rst wb_data", wb_data, 32'd0);
        rst_n = 1'b1;

        // first accept on first edge after release; LW full word
        run_load("lw", 5'd5, 5'd3, 12'h004, 3'b010, 32'h1000, 32'hDEADBEEF,
                 32'h1004, 32'hDEADBEEF, 1'b1);
        run_load("lb", 5'd6, 5'd4, 12'h000, 3'b000, 32'h1003, 32'h80FFFFFF,
                 32'h1000, 32'hFFFFFF80, 1'b1);
        run_load("lbu", 5'd6, 5'd4, 12'h000, 3'b100, 32'h1003, 32'h80FFFFFF,
                 32'h1000, 32'h00000080, 1'b1);
        run_load("lh", 5'd7, 5'd9, 12'hFFE, 3'b001, 32'h2000, 32'h80011234,
                 32'h1FFC, 32'hFFFF8001, 1'b1);
        run_load("lhu", 5'd7, 5'd10, 12'h010, 3'b101, 32'h2000, 32'h8001F234,
                 32'h2010, 32'h0000F234, 1'b1);
        run_load("lb1", 5'd8, 5'd11, 12'h001, 3'b000, 32'h3000, 32'h00007F00,
                 32'h3000, 32'h0000007F, 1'b1);
        run_load("lw_rd0", 5'd5, 5'd0, 12'h008, 3'b010, 32'h1000, 32'h12345678,
                 32'h1008, 32'h12345678, 1'b0);

        // backpressure on request with a stray response while in REQ
        rf[12] = 32'h4000;
        issue_valid = 1'b1; rs1 = 5'd12; rd = 5'd13; imm = 12'h00C; funct3 = 3'b010;
        mem_req_ready = 1'b0;
        tick();
        issue_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hBAD0BAD0;
            #1;
            check("stall req_valid", 32'(mem_req_valid), 32'd1);
            check("stall mem_addr", mem_addr, 32'h400C);
            tick();
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        check("stall still req", 32'(mem_req_valid), 32'd1);
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hCAFEF00D;
        tick();
        mem_rsp_valid = 1'b0;
        check("stall wb_en", 32'(wb_en), 32'd1);
        check("stall wb_data", wb_data, 32'hCAFEF00D);
        tick();

        // illegal funct3
        issue_valid = 1'b1; rs1 = 5'd5; rd = 5'd14; imm = 12'h0; funct3 = 3'b011;
        tick();
        issue_valid = 1'b0;
        check("illegal pulse", 32'(illegal_err), 32'd1);
        check("illegal no req", 32'(mem_req_valid), 32'd0);
        tick();
        check("illegal off", 32'(illegal_err), 32'd0);
        check("illegal idle", 32'(issue_ready), 32'd1);
        check("illegal no req2", 32'(mem_req_valid), 32'd0);
        check("illegal no wb", 32'(wb_en), 32'd0);

        // misaligned LW at EA=0x1002
        rf[15] = 32'h1000;
`ifdef LOAD_MISALIGN_TRAP_EN
        issue_valid = 1'b1; rs1 = 5'd15; rd = 5'd16; imm = 12'h002; funct3 = 3'b010;
        tick();
        issue_valid = 1'b0;
        check("misalign pulse", 32'(misalign_err), 32'd1);
        check("misalign no req", 32'(mem_req_valid), 32'd0);
        tick();
        check("misalign off", 32'(misalign_err), 32'd0);
        check("misalign idle", 32'(issue_ready), 32'd1);
        check("misalign no req2", 32'(mem_req_valid), 32'd0);
`else
        run_load("lw_mis", 5'd15, 5'd16, 12'h002, 3'b010, 32'h1000, 32'h11223344,
                 32'h1000, 32'h11223344, 1'b1);
`endif

        // asynchronous reset while waiting for the response
        rf[17] = 32'h5000;
        issue_valid = 1'b1; rs1 = 5'd17; rd = 5'd18; imm = 12'h0; funct3 = 3'b010;
        tick();
        issue_valid = 1'b0;
        tick();
        tick();
        check("pre-rst busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst outs", 32'({mem_req_valid, wb_en}), 32'd0);
        check("midrst raddr", 32'(rf_raddr), 32'd0);
        check("midrst wb_data", wb_data, 32'd0);
        tick();
        rst_n = 1'b1;
        run_load("post-rst", 5'd5, 5'd19, 12'h010, 3'b010, 32'h1000, 32'h0BADCAFE,
                 32'h1010, 32'h0BADCAFE, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
